// File: rtl/fixed_pkg.sv
// Shared definitions for the keypad-to-12.4 fixed-point converter:
// the FSM encoding, the decimal/binary scaling constants and the
// shift-add multiply-by-ten helper used by both accumulators.
package fixed_pkg;

    typedef enum logic [2:0] {
        INT_ENTRY  = 3'd0,
        FRAC_ENTRY = 3'd1,
        PAD        = 3'd2,
        DIV        = 3'd3,
        OUT        = 3'd4
    } state_t;

    // One 1/16 step expressed in units of 0.0001.
    localparam logic [13:0] FRAC_STEP  = 14'd625;
    localparam logic [2:0]  MAX_DIGITS = 3'd4;
    // Largest integer part that fits a positive 12.4 value.
    localparam logic [13:0] INT_MAX    = 14'd2047;
    localparam logic [15:0] POS_SAT    = 16'h7FFF;
    localparam logic [15:0] NEG_SAT    = 16'h8000;

    // x*10 as (x<<3)+(x<<1). Callers only pass values of at most 999,
    // so the 14-bit result never truncates a significant bit.
    function automatic logic [13:0] times_ten(input logic [13:0] x);
        return {x[10:0], 3'b000} + {x[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/frac_nibble_divider.sv
// Fixed-latency restoring divider: counts how many times 625 fits into the
// padded fraction, giving the 4-bit binary fraction by truncation.
// A start pulse loads the dividend and runs the first step; done is high
// in the 16th cycle, and nib holds its final value until the next start.
module frac_nibble_divider
    import fixed_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic [13:0] dividend,
    output logic [3:0]  nib,
    output logic        done,
    output logic        busy
);

    logic [13:0] rem;
    logic [3:0]  step_cnt;
    logic        running;
    logic [13:0] cur_rem;
    logic [3:0]  cur_nib;
    logic [13:0] step_rem;
    logic [3:0]  step_nib;

    // One subtract-and-count step, fed from the dividend on the start cycle.
    // The dividend is at most 9999, so nib tops out at 15 and cannot wrap.
    always_comb begin
        cur_rem  = start ? dividend : rem;
        cur_nib  = start ? 4'd0 : nib;
        step_rem = cur_rem;
        step_nib = cur_nib;
        if (cur_rem >= FRAC_STEP) begin
            step_rem = cur_rem - FRAC_STEP;
            step_nib = cur_nib + 4'd1;
        end
    end

    assign done = running && (step_cnt == 4'd15);
    assign busy = running;

    // Iteration registers: advance on start and while running, stop after 16 steps.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem      <= 14'd0;
            nib      <= 4'd0;
            step_cnt <= 4'd0;
            running  <= 1'b0;
        end else if (start || running) begin
            rem <= step_rem;
            nib <= step_nib;
            if (start) begin
                step_cnt <= 4'd1;
                running  <= 1'b1;
            end else if (done) begin
                step_cnt <= 4'd0;
                running  <= 1'b0;
            end else begin
                step_cnt <= step_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/decimal_to_twelve_four_fixed.sv
// Keypad decimal entry (up to 4 integer and 4 fraction digits plus sign)
// converted to a saturating signed 12.4 two's-complement value.
// A conversion takes 4 pad cycles, 16 divide cycles and 1 output cycle.
module decimal_to_twelve_four_fixed (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        point,
    input  logic        neg_toggle,
    input  logic        enter,
    input  logic        clear,
    output logic [15:0] val,
    output logic        val_valid,
    output logic        overflow,
    output logic        busy,
    output logic        is_negative
);

    import fixed_pkg::*;

    state_t      state;
    state_t      state_next;
    logic [13:0] int_acc;
    logic [13:0] frac_acc;
    logic [2:0]  int_cnt;
    logic [2:0]  frac_cnt;
    logic [1:0]  pad_cnt;

    logic        in_entry;
    logic        act_enter;
    logic        act_point;
    logic        act_neg;
    logic        act_digit;

    logic        div_start;
    logic        div_done;
    logic        div_busy;
    logic [3:0]  div_nib;

    logic [17:0] full_mag;
    logic [15:0] result_val;
    logic        result_ovf;

    // Strobe decode: only the highest-priority strobe acts, and only while entering.
    always_comb begin
        in_entry  = (state == INT_ENTRY) || (state == FRAC_ENTRY);
        act_enter = in_entry && !clear && enter;
        act_point = in_entry && !clear && !enter && point;
        act_neg   = in_entry && !clear && !enter && !point && neg_toggle;
        act_digit = in_entry && !clear && !enter && !point && !neg_toggle
                    && digit_valid && (digit <= 4'd9);
    end

    // Next-state logic; clear overrides everything and returns to entry.
    always_comb begin
        state_next = state;
        case (state)
            INT_ENTRY: begin
                if (act_enter) begin
                    state_next = PAD;
                end else if (act_point) begin
                    state_next = FRAC_ENTRY;
                end
            end
            FRAC_ENTRY: begin
                if (act_enter) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                if (pad_cnt == 2'd3) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                state_next = INT_ENTRY;
            end
            default: begin
                state_next = INT_ENTRY;
            end
        endcase
        if (clear) begin
            state_next = INT_ENTRY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INT_ENTRY;
        end else begin
            state <= state_next;
        end
    end

    assign busy      = (state == PAD) || (state == DIV) || (state == OUT);
    assign div_start = (state == DIV) && !div_busy;

    frac_nibble_divider u_divider (
        .clk      (clk),
        .rst      (rst),
        .abort    (clear),
        .start    (div_start),
        .dividend (frac_acc),
        .nib      (div_nib),
        .done     (div_done),
        .busy     (div_busy)
    );

    // Signed result with saturation. The full 18-bit magnitude is compared so
    // that integer parts beyond 12 bits always saturate, while exactly -2048.0
    // stays representable as 0x8000 without flagging overflow.
    always_comb begin
        full_mag   = {int_acc, div_nib};
        result_val = full_mag[15:0];
        result_ovf = 1'b0;
        if (is_negative) begin
            if (full_mag > {2'b00, NEG_SAT}) begin
                result_val = NEG_SAT;
                result_ovf = 1'b1;
            end else begin
                result_val = 16'h0000 - full_mag[15:0];
            end
        end else if (int_acc > INT_MAX) begin
            result_val = POS_SAT;
            result_ovf = 1'b1;
        end
    end

    // Entry accumulators, fraction padding and the registered result.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            int_acc     <= 14'd0;
            frac_acc    <= 14'd0;
            int_cnt     <= 3'd0;
            frac_cnt    <= 3'd0;
            pad_cnt     <= 2'd0;
            is_negative <= 1'b0;
            val         <= 16'h0000;
            val_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            val_valid <= 1'b0;
            case (state)
                INT_ENTRY: begin
                    if (act_neg) begin
                        is_negative <= ~is_negative;
                    end
                    if (act_digit && (int_cnt < MAX_DIGITS)) begin
                        int_acc <= times_ten(int_acc) + {10'd0, digit};
                        int_cnt <= int_cnt + 3'd1;
                    end
                end
                FRAC_ENTRY: begin
                    if (act_neg) begin
                        is_negative <= ~is_negative;
                    end
                    if (act_digit && (frac_cnt < MAX_DIGITS)) begin
                        frac_acc <= times_ten(frac_acc) + {10'd0, digit};
                        frac_cnt <= frac_cnt + 3'd1;
                    end
                end
                PAD: begin
                    if (({1'b0, frac_cnt} + {2'b00, pad_cnt}) < 4'd4) begin
                        frac_acc <= times_ten(frac_acc);
                    end
                    pad_cnt <= pad_cnt + 2'd1;
                end
                OUT: begin
                    val         <= result_val;
                    overflow    <= result_ovf;
                    val_valid   <= 1'b1;
                    int_acc     <= 14'd0;
                    frac_acc    <= 14'd0;
                    int_cnt     <= 3'd0;
                    frac_cnt    <= 3'd0;
                    is_negative <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_to_twelve_four_fixed.sv
// Directed scenarios for the keypad-to-12.4 converter. Expected results are
// pushed to a scoreboard when enter is pressed and popped when val_valid fires.
module tb_decimal_to_twelve_four_fixed;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        point = 1'b0;
    logic        neg_toggle = 1'b0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] val;
    logic        val_valid;
    logic        overflow;
    logic        busy;
    logic        is_negative;

    typedef struct packed {
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    decimal_to_twelve_four_fixed dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .point       (point),
        .neg_toggle  (neg_toggle),
        .enter       (enter),
        .clear       (clear),
        .val         (val),
        .val_valid   (val_valid),
        .overflow    (overflow),
        .busy        (busy),
        .is_negative (is_negative)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every press task drives at the falling edge, is sampled by exactly one
    // rising edge, and returns 1 time unit after that edge.
    task automatic press_digit(input logic [3:0] d);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic press_point();
        @(negedge clk);
        point = 1'b1;
        @(posedge clk);
        #1;
        point = 1'b0;
    endtask

    task automatic press_neg();
        @(negedge clk);
        neg_toggle = 1'b1;
        @(posedge clk);
        #1;
        neg_toggle = 1'b0;
    endtask

    task automatic press_enter();
        @(negedge clk);
        enter = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
    endtask

    task automatic press_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic press_combo(input logic e, input logic p, input logic n, input logic [3:0] d);
        @(negedge clk);
        enter       = e;
        point       = p;
        neg_toggle  = n;
        digit_valid = 1'b1;
        digit       = d;
        @(posedge clk);
        #1;
        enter       = 1'b0;
        point       = 1'b0;
        neg_toggle  = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [15:0] v, input logic o);
        exp_t e;
        e.val = v;
        e.ovf = o;
        sb.push_back(e);
    endtask

    // Waits up to 40 edges for val_valid; edges stays 0 if it never comes.
    task automatic wait_result(output int edges);
        int n;
        n     = 0;
        edges = 0;
        while (edges == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (val_valid === 1'b1) edges = n;
        end
    endtask

    task automatic test_reset();
        checks++; if (val !== 16'h0000) begin fails++; $display("[TB] FAIL reset_val: got %h, want 0000", val); end
        checks++; if (val_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_val_valid: got %b, want 0", val_valid); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b, want 0", overflow); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (is_negative !== 1'b0) begin fails++; $display("[TB] FAIL reset_is_negative: got %b, want 0", is_negative); end
    endtask

    task automatic test_positive_fraction();
        int   edges;
        exp_t e;
        press_digit(4'd1); press_digit(4'd2); press_point(); press_digit(4'd5);
        expect_result(16'h00C8, 1'b0);
        press_enter();
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL pos_busy: got %b, want 1", busy); end
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges != 21) begin fails++; $display("[TB] FAIL pos_latency: got %0d edges, want 21", edges); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL pos_val: got %h, want %h", val, e.val); end
        checks++; if (overflow !== e.ovf) begin fails++; $display("[TB] FAIL pos_overflow: got %b, want %b", overflow, e.ovf); end
        idle(1);
        checks++; if (val_valid !== 1'b0) begin fails++; $display("[TB] FAIL pos_one_cycle: val_valid got %b, want 0", val_valid); end
        idle(3);
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL pos_hold: got %h, want %h", val, e.val); end
    endtask

    task automatic test_negative_fraction();
        int   edges;
        exp_t e;
        press_neg();
        checks++; if (is_negative !== 1'b1) begin fails++; $display("[TB] FAIL neg_sign: got %b, want 1", is_negative); end
        press_digit(4'd3); press_point(); press_digit(4'd0); press_digit(4'd6);
        press_digit(4'd2); press_digit(4'd5);
        expect_result(16'hFFCF, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges != 21) begin fails++; $display("[TB] FAIL neg_latency: got %0d edges, want 21", edges); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL neg_val: got %h, want %h", val, e.val); end
        checks++; if (is_negative !== 1'b0) begin fails++; $display("[TB] FAIL neg_sign_cleared: got %b, want 0", is_negative); end
    endtask

    task automatic test_fraction_only();
        int   edges;
        exp_t e;
        press_point(); press_digit(4'd9); press_digit(4'd9); press_digit(4'd9); press_digit(4'd9);
        expect_result(16'h000F, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL frac_9999_val: got %h, want %h", val, e.val); end
        press_point(); press_digit(4'd1);
        expect_result(16'h0001, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges != 21) begin fails++; $display("[TB] FAIL frac_1_latency: got %0d edges, want 21", edges); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL frac_1_val: got %h, want %h", val, e.val); end
    endtask

    task automatic test_digit_limits();
        int   edges;
        exp_t e;
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4); press_digit(4'd5);
        expect_result(16'h4D20, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL int_limit_val: got %h, want %h", val, e.val); end
        press_digit(4'd1); press_point(); press_digit(4'd9); press_digit(4'd3);
        press_digit(4'd7); press_digit(4'd5); press_digit(4'd9); press_point();
        expect_result(16'h001F, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL frac_limit_val: got %h, want %h", val, e.val); end
    endtask

    task automatic test_priority();
        int   edges;
        exp_t e;
        press_digit(4'd6);
        press_combo(1'b0, 1'b0, 1'b1, 4'd9);
        press_combo(1'b1, 1'b1, 1'b1, 4'd3);
        expect_result(16'hFFA0, 1'b0);
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges != 21) begin fails++; $display("[TB] FAIL prio_latency: got %0d edges, want 21", edges); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL prio_val: got %h, want %h", val, e.val); end
    endtask

    task automatic test_saturation();
        int   edges;
        exp_t e;
        press_digit(4'd2); press_digit(4'd0); press_digit(4'd4); press_digit(4'd8);
        expect_result(16'h7FFF, 1'b1);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL sat_pos_val: got %h, want %h", val, e.val); end
        checks++; if (overflow !== e.ovf) begin fails++; $display("[TB] FAIL sat_pos_overflow: got %b, want %b", overflow, e.ovf); end
        press_neg(); press_digit(4'd2); press_digit(4'd0); press_digit(4'd4); press_digit(4'd8);
        expect_result(16'h8000, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL sat_neg2048_val: got %h, want %h", val, e.val); end
        checks++; if (overflow !== e.ovf) begin fails++; $display("[TB] FAIL sat_neg2048_overflow: got %b, want %b", overflow, e.ovf); end
        press_neg(); press_digit(4'd2); press_digit(4'd0); press_digit(4'd4); press_digit(4'd8);
        press_point(); press_digit(4'd5);
        expect_result(16'h8000, 1'b1);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (overflow !== e.ovf) begin fails++; $display("[TB] FAIL sat_neg_over_overflow: got %b, want %b", overflow, e.ovf); end
        press_digit(4'd9); press_digit(4'd9); press_digit(4'd9); press_digit(4'd9);
        expect_result(16'h7FFF, 1'b1);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL sat_9999_val: got %h, want %h", val, e.val); end
        checks++; if (overflow !== e.ovf) begin fails++; $display("[TB] FAIL sat_9999_overflow: got %b, want %b", overflow, e.ovf); end
    endtask

    task automatic test_clear_abort();
        int edges;
        press_digit(4'd7);
        press_enter();
        idle(4);
        press_clear();
        checks++; if (val !== 16'h0000) begin fails++; $display("[TB] FAIL clear_val: got %h, want 0000", val); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL clear_overflow: got %b, want 0", overflow); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL clear_busy: got %b, want 0", busy); end
        wait_result(edges);
        checks++; if (edges != 0) begin fails++; $display("[TB] FAIL clear_no_valid: val_valid after %0d edges, want none", edges); end
    endtask

    task automatic test_back_to_back();
        int   edges;
        exp_t e;
        press_digit(4'd1); press_digit(4'd2); press_point(); press_digit(4'd5);
        expect_result(16'h00C8, 1'b0);
        press_enter();
        idle(2);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_busy: got %b, want 1", busy); end
        press_digit(4'd9); press_neg(); press_point(); press_enter();
        checks++; if (is_negative !== 1'b0) begin fails++; $display("[TB] FAIL b2b_neg_ignored: got %b, want 0", is_negative); end
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges + 6 != 21) begin fails++; $display("[TB] FAIL b2b_latency: got %0d edges, want 21", edges + 6); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL b2b_first_val: got %h, want %h", val, e.val); end
        press_neg(); press_point(); press_digit(4'd5);
        expect_result(16'hFFF8, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL b2b_second_val: got %h, want %h", val, e.val); end
    endtask

    task automatic test_reset_mid_entry();
        int   edges;
        exp_t e;
        press_digit(4'd4); press_digit(4'd12); press_point();
        pulse_reset();
        checks++; if (val !== 16'h0000) begin fails++; $display("[TB] FAIL rst_entry_val: got %h, want 0000", val); end
        press_digit(4'd12); press_digit(4'd2); press_digit(4'd12);
        expect_result(16'h0020, 1'b0);
        press_enter();
        wait_result(edges);
        e = sb.pop_front();
        checks++; if (edges != 21) begin fails++; $display("[TB] FAIL rst_entry_latency: got %0d edges, want 21", edges); end
        checks++; if (val !== e.val) begin fails++; $display("[TB] FAIL rst_entry_result: got %h, want %h", val, e.val); end
        press_digit(4'd3);
        press_enter();
        idle(3);
        pulse_reset();
        wait_result(edges);
        checks++; if (edges != 0) begin fails++; $display("[TB] FAIL rst_conv_no_valid: val_valid after %0d edges, want none", edges); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_conv_busy: got %b, want 0", busy); end
    endtask

    initial begin
        $display("[TB] starting decimal_to_twelve_four_fixed bench");
        idle(3);
        rst = 1'b0;
        test_reset();
        test_positive_fraction();
        test_negative_fraction();
        test_fraction_only();
        test_digit_limits();
        test_priority();
        test_saturation();
        test_clear_abort();
        test_back_to_back();
        test_reset_mid_entry();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
